hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline interlock controller for the DLX integer pipeline. Sits beside the decode stage. Tracks destination registers of instructions in flight in EX, MEM and WB with a three-entry scoreboard. From that it generates decode/fetch stalls, ID/EX bubbles, IF/ID flushes on taken control transfers, and registered operand-forwarding selects aligned with the ID/EX pipe register.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register address width
- STALL_CNT_WIDTH, 16, width of saturating stall-cycle counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_read_address1  in  REG_ADDR_WIDTH  source register A of decoding instruction
- id_read_address2  in  REG_ADDR_WIDTH  source register B
- id_uses_b  in  1  instruction reads register B (0 for immediate forms)
- id_reg_wr_en  in  1  decoding instruction writes a register
- id_reg_wr_addr  in  REG_ADDR_WIDTH  its destination
- id_mem_data_rd_en  in  1  decoding instruction is a load
- ex_ctrl_taken  in  1  branch taken or jump resolved in EX this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- id_ex_bubble  out  1  load NOP control into ID/EX
- if_id_flush  out  1  clear IF/ID register
- fwd_a_sel  out  2  ALU A source for instruction now in EX: 0 register bank, 1 EX/MEM, 2 MEM/WB
- fwd_b_sel  out  2  same for ALU B
- stall_cycles_out  out  STALL_CNT_WIDTH  saturating count of stall cycles since reset

## Operation
- Scoreboard entries EX, MEM, WB, each {valid, wr_en, addr, is_load}. Every cycle: WB<=MEM, MEM<=EX, EX<=decode instruction, or an invalid entry when stalling, bubbling or flushing.
- Hazard match: entry valid, wr_en=1, addr!=0, addr equals id_read_address1 or (id_uses_b and id_read_address2). Register 0 never matches. Match is checked only when id_valid=1.
- hazard (forwarding build): EX entry matches and EX.is_load=1.
- FSM states: RUN, STALL, FLUSH.
  - RUN->FLUSH on ex_ctrl_taken.
  - RUN->STALL on hazard.
  - STALL->RUN when hazard clears.
  - STALL->FLUSH on ex_ctrl_taken.
  - FLUSH->RUN unconditionally after one cycle.
- Outputs are Mealy, derived from state, scoreboard and current inputs:
  - ex_ctrl_taken: if_id_flush=1, id_ex_bubble=1, pc_stall=0. Flush takes priority over any hazard.
  - else hazard: pc_stall=if_id_stall=id_ex_bubble=1.
  - else all 0.
- Forwarding selects are registered, updated on the edge where the decode instruction enters ID/EX.
  - Per operand: 1 if the EX entry matches that operand.
  - Else 2 if the MEM entry matches.
  - Else 0.
  - Selects are forced to 0 when the decode instruction is bubbled or flushed.
- stall_cycles_out increments on every cycle with pc_stall=1. It saturates at all-ones.

## Timing
- Reset: scoreboard invalid, state RUN, all outputs 0, counter 0. Reset mid-stall or mid-flush discards all state immediately.
- Load-use: exactly 1 stall cycle with forwarding.
- Flush: 1 cycle; the instruction in IF/ID and the decode instruction are both discarded.
- Register bank writes become readable the cycle after WB.
- Simultaneous hazard and ex_ctrl_taken: flush only, no stall counted.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - Hazard is a match in any of the EX, MEM or WB entries, regardless of is_load.
  - A dependent instruction stalls up to 3 cycles until its producer has left WB.

## Structure
- Shared package holds:
  - forwarding-select constants FWD_REGBANK=0, FWD_EX_MEM=1, FWD_MEM_WB=2
  - FSM state encoding
  - scoreboard entry typedef
- One sub-module, hazard_match: combinational compare of one scoreboard entry against the two source addresses, with the r0 exclusion.

## Test plan
- LW r3 followed by ADD r4,r3,r5 (FORWARDING_EN) -> one cycle with pc_stall=if_id_stall=id_ex_bubble=1; ADD enters EX with fwd_a_sel=2; stall_cycles_out=1.
- ADD r3 followed by SUB r6,r1,r3 -> no stall; fwd_b_sel=1 when SUB is in EX.
- Without FORWARDING_EN, same ADD/SUB pair -> 3 stall cycles; selects stay 0.
- Writer to r0 followed by a reader of r0 -> no stall, selects 0.
- ex_ctrl_taken asserted during a load-use stall -> if_id_flush=1 and id_ex_bubble=1 for one cycle; pc_stall=0; state returns to RUN; counter not incremented.
- rst_n pulsed low mid-stall -> all outputs 0 asynchronously; the next dependent instruction after release is evaluated against an empty scoreboard.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the DLX pipeline interlock controller.
// Holds forwarding-select encodings, the FSM state encoding and the
// scoreboard entry layout used by the top level and the match sub-module.
package hazard_control_unit_pkg;

  // Scoreboard entries carry register addresses of this width.
  // REG_ADDR_WIDTH on the top level must equal this value.
  localparam int SB_ADDR_WIDTH = 5;

  // ALU operand source selects, as seen by the EX stage.
  localparam logic [1:0] FWD_REGBANK = 2'd0;
  localparam logic [1:0] FWD_EX_MEM  = 2'd1;
  localparam logic [1:0] FWD_MEM_WB  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hcu_state_e;

  typedef struct packed {
    logic                     valid;
    logic                     wr_en;
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic                     is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Decode-side bundle between the decode stage and the interlock controller.
// master: decode stage (drives instruction fields, reads stall/flush/fwd);
// slave: hazard_control_unit. No handshake; all signals are per-cycle levels.
interface hazard_control_unit_if #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
);
  logic                       id_valid;
  logic [REG_ADDR_WIDTH-1:0]  id_read_address1;
  logic [REG_ADDR_WIDTH-1:0]  id_read_address2;
  logic                       id_uses_b;
  logic                       id_reg_wr_en;
  logic [REG_ADDR_WIDTH-1:0]  id_reg_wr_addr;
  logic                       id_mem_data_rd_en;
  logic                       ex_ctrl_taken;

  logic                       pc_stall;
  logic                       if_id_stall;
  logic                       id_ex_bubble;
  logic                       if_id_flush;
  logic [1:0]                 fwd_a_sel;
  logic [1:0]                 fwd_b_sel;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles_out;

  modport master (
    output id_valid, id_read_address1, id_read_address2, id_uses_b,
           id_reg_wr_en, id_reg_wr_addr, id_mem_data_rd_en, ex_ctrl_taken,
    input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
           fwd_a_sel, fwd_b_sel, stall_cycles_out
  );

  modport slave (
    input  id_valid, id_read_address1, id_read_address2, id_uses_b,
           id_reg_wr_en, id_reg_wr_addr, id_mem_data_rd_en, ex_ctrl_taken,
    output pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
           fwd_a_sel, fwd_b_sel, stall_cycles_out
  );
endinterface

// File: rtl/hazard_control_unit_hazard_match.sv
// Compares one scoreboard entry against the decoding instruction's sources.
// Latency: purely combinational.
// Backpressure: none; match outputs feed the stall/forward decisions.
// Ports: entry (scoreboard slot), id_valid, rd_addr_a/b, uses_b -> match_a/b.
module hazard_match
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = SB_ADDR_WIDTH
) (
  input  sb_entry_t                 entry,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  input  logic                      uses_b,
  output logic                      match_a,
  output logic                      match_b
);
  logic live;
  // is_load is consumed by the top-level hazard policy, not here.
  logic unused_is_load;

  assign unused_is_load = entry.is_load;

  always_comb begin
    // r0 is hardwired zero, so a writer to r0 never creates a dependency.
    live    = id_valid && entry.valid && entry.wr_en && (entry.addr != '0);
    match_a = live && (entry.addr == rd_addr_a);
    match_b = live && uses_b && (entry.addr == rd_addr_b);
  end
endmodule

// File: rtl/hazard_control_unit.sv
// DLX pipeline interlock: EX/MEM/WB scoreboard driving stall, bubble, flush, fwd selects.
// Latency: stall/bubble/flush are same-cycle (Mealy); fwd selects registered into ID/EX.
// Backpressure: pc_stall/if_id_stall hold fetch+decode while a hazard is open.
// Ports: clk, rst_n (async active-low), bus (hazard_control_unit_if.slave).
// Build option FORWARDING_EN: defined -> only load-use stalls, selects live;
// undefined -> stall on any EX/MEM/WB dependency, selects tied to register bank.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = SB_ADDR_WIDTH,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave bus
);
  sb_entry_t  sb_ex, sb_mem, sb_wb, sb_new;
  hcu_state_e state;
  logic       ex_ma, ex_mb, mem_ma, mem_mb, wb_ma, wb_mb;
  logic       hazard, taken;
  logic       pc_stall, id_ex_bubble, if_id_flush;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

  hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match_ex (
    .entry(sb_ex), .id_valid(bus.id_valid),
    .rd_addr_a(bus.id_read_address1), .rd_addr_b(bus.id_read_address2),
    .uses_b(bus.id_uses_b), .match_a(ex_ma), .match_b(ex_mb)
  );
  hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match_mem (
    .entry(sb_mem), .id_valid(bus.id_valid),
    .rd_addr_a(bus.id_read_address1), .rd_addr_b(bus.id_read_address2),
    .uses_b(bus.id_uses_b), .match_a(mem_ma), .match_b(mem_mb)
  );
  hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match_wb (
    .entry(sb_wb), .id_valid(bus.id_valid),
    .rd_addr_a(bus.id_read_address1), .rd_addr_b(bus.id_read_address2),
    .uses_b(bus.id_uses_b), .match_a(wb_ma), .match_b(wb_mb)
  );

  assign taken = bus.ex_ctrl_taken;

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; everything else bypasses.
  logic unused_wb_match;
  assign unused_wb_match = wb_ma | wb_mb;
  assign hazard = (ex_ma | ex_mb) & sb_ex.is_load;
`else
  // Without bypass, wait until the producer has written the register bank.
  assign hazard = ex_ma | ex_mb | mem_ma | mem_mb | wb_ma | wb_mb;
`endif

  // A taken control transfer squashes the decode instruction, so any hazard
  // it carried is moot: flush wins and no stall is taken.
  always_comb begin
    if_id_flush  = taken;
    id_ex_bubble = taken | hazard;
    pc_stall     = !taken & hazard;
  end

  assign bus.pc_stall         = pc_stall;
  assign bus.if_id_stall      = pc_stall;
  assign bus.id_ex_bubble     = id_ex_bubble;
  assign bus.if_id_flush      = if_id_flush;
  assign bus.stall_cycles_out = stall_cnt_q;

  always_comb begin
    sb_new = SB_EMPTY;
    if (bus.id_valid && !id_ex_bubble) begin
      sb_new.valid   = 1'b1;
      sb_new.wr_en   = bus.id_reg_wr_en;
      sb_new.addr    = bus.id_reg_wr_addr;
      sb_new.is_load = bus.id_mem_data_rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex       <= SB_EMPTY;
      sb_mem      <= SB_EMPTY;
      sb_wb       <= SB_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= sb_new;
      if (pc_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (taken) state <= ST_FLUSH;
                  else if (hazard) state <= ST_STALL;
        ST_STALL: if (taken) state <= ST_FLUSH;
                  else if (!hazard) state <= ST_RUN;
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

`ifdef FORWARDING_EN
  logic [1:0] fwd_a_nxt, fwd_b_nxt, fwd_a_q, fwd_b_q;

  // Youngest producer wins: EX/MEM result is newer than MEM/WB.
  always_comb begin
    fwd_a_nxt = FWD_REGBANK;
    fwd_b_nxt = FWD_REGBANK;
    if (ex_ma)       fwd_a_nxt = FWD_EX_MEM;
    else if (mem_ma) fwd_a_nxt = FWD_MEM_WB;
    if (ex_mb)       fwd_b_nxt = FWD_EX_MEM;
    else if (mem_mb) fwd_b_nxt = FWD_MEM_WB;
    if (id_ex_bubble) begin
      fwd_a_nxt = FWD_REGBANK;
      fwd_b_nxt = FWD_REGBANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_REGBANK;
      fwd_b_q <= FWD_REGBANK;
    end else begin
      fwd_a_q <= fwd_a_nxt;
      fwd_b_q <= fwd_b_nxt;
    end
  end

  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;
`else
  assign bus.fwd_a_sel = FWD_REGBANK;
  assign bus.fwd_b_sel = FWD_REGBANK;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one vector per cycle, inputs applied
// at negedge, outputs sampled before the next posedge; expectations follow
// the FORWARDING_EN build option.
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  localparam logic [3:0] N = 4'b0000;  // {pc_stall, if_id_stall, bubble, flush}
  localparam logic [3:0] S = 4'b1110;
  localparam logic [3:0] F = 4'b0011;

  typedef struct {
    logic       v;
    logic [4:0] a1, a2;
    logic       ub, we;
    logic [4:0] wa;
    logic       ld, tk;
    logic [3:0] ctl;
    logic [1:0] fa, fb;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hazard_control_unit_if #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(16)) bus ();

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic vec_t mk(logic v, logic [4:0] a1, logic [4:0] a2, logic ub,
                              logic we, logic [4:0] wa, logic ld, logic tk,
                              logic [3:0] ctl, logic [1:0] fa, logic [1:0] fb,
                              logic [15:0] cnt);
    vec_t t;
    t.v = v; t.a1 = a1; t.a2 = a2; t.ub = ub; t.we = we; t.wa = wa;
    t.ld = ld; t.tk = tk; t.ctl = ctl; t.fa = fa; t.fb = fb; t.cnt = cnt;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    bus.id_valid          = t.v;
    bus.id_read_address1  = t.a1;
    bus.id_read_address2  = t.a2;
    bus.id_uses_b         = t.ub;
    bus.id_reg_wr_en      = t.we;
    bus.id_reg_wr_addr    = t.wa;
    bus.id_mem_data_rd_en = t.ld;
    bus.ex_ctrl_taken     = t.tk;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ctl,
                           input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
    check({tag, " ctl"}, {28'd0, bus.pc_stall, bus.if_id_stall, bus.id_ex_bubble, bus.if_id_flush},
          {28'd0, ctl});
    check({tag, " fwd_a"}, {30'd0, bus.fwd_a_sel}, {30'd0, fa});
    check({tag, " fwd_b"}, {30'd0, bus.fwd_b_sel}, {30'd0, fb});
    check({tag, " cnt"}, {16'd0, bus.stall_cycles_out}, {16'd0, cnt});
  endtask

  initial begin
    vec_t idle, prod, rdr;
    logic [15:0] cnt_before;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 0);

`ifdef FORWARDING_EN
    // ADD r3 ; SUB r6,r1,r3 -> bypass from EX/MEM on B
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 0, 0, N, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 6, 0, 0, N, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, FWD_REGBANK, FWD_EX_MEM, 0));
    // LW r3 ; ADD r4,r3,r5 -> one stall then MEM/WB bypass on A
    vecs.push_back(mk(1, 1, 0, 0, 1, 3, 1, 0, N, 0, 0, 0));
    vecs.push_back(mk(1, 3, 5, 1, 1, 4, 0, 0, S, 0, 0, 0));
    vecs.push_back(mk(1, 3, 5, 1, 1, 4, 0, 0, N, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, FWD_MEM_WB, FWD_REGBANK, 1));
    // r9 written twice in a row; reader picks the younger (EX) copy
    vecs.push_back(mk(1, 1, 2, 1, 1, 9, 0, 0, N, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2, 1, 1, 9, 0, 0, N, 0, 0, 1));
    vecs.push_back(mk(1, 9, 9, 1, 1, 10, 0, 0, N, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, FWD_EX_MEM, FWD_EX_MEM, 1));
    // writer r0 ; reader r0 -> nothing
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, N, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 7, 0, 0, N, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 1));
    // load-use with taken branch: flush only, no stall counted, selects forced 0
    vecs.push_back(mk(1, 1, 0, 0, 1, 3, 1, 0, N, 0, 0, 1));
    vecs.push_back(mk(1, 3, 5, 1, 1, 4, 0, 1, F, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 1));
    // EX bypass candidate flushed -> selects forced 0
    vecs.push_back(mk(1, 1, 2, 1, 1, 11, 0, 0, N, 0, 0, 1));
    vecs.push_back(mk(1, 11, 2, 1, 1, 12, 0, 1, F, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 1));
    cnt_before = 16'd1;
`else
    // ADD r3 ; SUB r6,r1,r3 -> three stalls until ADD leaves WB
    vecs.push_back(mk(1, 1, 2, 1, 1, 3, 0, 0, N, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 6, 0, 0, S, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 6, 0, 0, S, 0, 0, 1));
    vecs.push_back(mk(1, 1, 3, 1, 1, 6, 0, 0, S, 0, 0, 2));
    vecs.push_back(mk(1, 1, 3, 1, 1, 6, 0, 0, N, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 3));
    // writer r0 ; reader r0 -> nothing
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, N, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 1, 1, 7, 0, 0, N, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 3));
    // immediate form ignores B even though r7 is in MEM
    vecs.push_back(mk(1, 4, 7, 0, 1, 8, 0, 0, N, 0, 0, 3));
    // invalid decode slot never matches
    vecs.push_back(mk(0, 8, 0, 0, 0, 0, 0, 0, N, 0, 0, 3));
    // stall on MEM match, then taken branch mid-stall -> flush only
    vecs.push_back(mk(1, 8, 0, 0, 1, 9, 0, 0, S, 0, 0, 3));
    vecs.push_back(mk(1, 8, 0, 0, 1, 9, 0, 1, F, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 4));
    // r8 producer gone and stalled copy never entered EX -> clean
    vecs.push_back(mk(1, 8, 0, 0, 1, 9, 0, 0, N, 0, 0, 4));
    // reader of r9 (in EX) with taken branch -> flush wins
    vecs.push_back(mk(1, 9, 0, 0, 1, 10, 0, 1, F, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 4));
    cnt_before = 16'd4;
`endif

    // Reset state
    rst_n = 1'b0;
    drive(idle);
    @(negedge clk);
    @(negedge clk);
    #2;
    check_all("reset", N, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check_all($sformatf("v%0d", i), vecs[i].ctl, vecs[i].fa, vecs[i].fb, vecs[i].cnt);
    end

    // Async reset in the middle of a load-use stall
    prod = mk(1, 1, 2, 1, 1, 3, 1, 0, N, 0, 0, 0);
    rdr  = mk(1, 3, 5, 1, 1, 4, 0, 0, N, 0, 0, 0);
    @(negedge clk);
    drive(idle);
    @(negedge clk);
    drive(prod);
    @(negedge clk);
    drive(rdr);
    #2;
    check_all("pre_rst", S, 0, 0, cnt_before);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("in_rst", N, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    drive(rdr);
    #2;
    check_all("post_rst", N, 0, 0, 0);
    @(negedge clk);
    drive(idle);
    #2;
    check_all("post_rst_ex", N, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
